// File: rtl/register_file_2w.sv
// register_file_2w
//
// Register file with two combinational read ports and two synchronous write
// ports. When both write ports hit the same register on one edge, port 4 wins
// and WR_CONFLICT is raised for the following cycle.
//
// Parameters
//   WIDTH    : data width of every register and data port
//   ADDR_W   : address width, DEPTH = 2**ADDR_W registers
//   ZERO_REG : 1 -> register 0 reads as zero and ignores writes
//   BYPASS   : 1 -> reads see same-cycle write data (write-through)
//
// Ports
//   clk         : rising-edge clock for all register updates
//   reset       : asynchronous, active-high; clears all storage and the flag
//   A1, A2      : read addresses          -> RD1, RD2 (combinational)
//   A3, WD3, WE : write port 3 (address, data, enable)
//   A4, WD4, WE4: write port 4 (address, data, enable), wins on collision
//   WR_CONFLICT : registered, both write ports targeted one register last edge
module register_file_2w #(
    parameter int WIDTH    = 32,
    parameter int ADDR_W   = 5,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] A1,
    input  logic [ADDR_W-1:0] A2,
    input  logic [ADDR_W-1:0] A3,
    input  logic [WIDTH-1:0]  WD3,
    input  logic              WE,
    input  logic [ADDR_W-1:0] A4,
    input  logic [WIDTH-1:0]  WD4,
    input  logic              WE4,
    output logic [WIDTH-1:0]  RD1,
    output logic [WIDTH-1:0]  RD2,
    output logic              WR_CONFLICT
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [WIDTH-1:0]  regs [DEPTH];

    logic              we3_ok;
    logic              we4_ok;
    logic [ADDR_W-1:0] ra [2];
    logic [WIDTH-1:0]  rd [2];

    // Enables are qualified with an explicit compare against 1 so an unknown
    // enable never opens a write. A write aimed at a hardwired zero register
    // is treated as no write at all, which also keeps it out of the conflict
    // flag and out of the bypass path.
    assign we3_ok = (WE  == 1'b1) && !(ZERO_REG && (A3 == '0));
    assign we4_ok = (WE4 == 1'b1) && !(ZERO_REG && (A4 == '0));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs        <= '{default: '0};
            WR_CONFLICT <= 1'b0;
        end else begin
            if (we3_ok) regs[A3] <= WD3;
            // Port 4 is written last so it overrides port 3 on a collision.
            if (we4_ok) regs[A4] <= WD4;
            WR_CONFLICT <= we3_ok && we4_ok && (A3 == A4);
        end
    end

    assign ra[0] = A1;
    assign ra[1] = A2;

    // Priority from weakest to strongest: stored value, port 3 bypass,
    // port 4 bypass, zero register, reset.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd[p] = regs[ra[p]];
            if (BYPASS) begin
                if (we3_ok && (A3 == ra[p])) rd[p] = WD3;
                if (we4_ok && (A4 == ra[p])) rd[p] = WD4;
            end
            if (ZERO_REG && (ra[p] == '0)) rd[p] = '0;
            if (reset) rd[p] = '0;
        end
    end

    assign RD1 = rd[0];
    assign RD2 = rd[1];

endmodule

// File: tb/tb_register_file_2w.sv
module tb_register_file_2w;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [4:0]  a1, a2, a3, a4;
  logic [31:0] wd3, wd4;
  logic        we, we4;

  // Three configurations share the same stimulus:
  //   0: ZERO_REG=1 BYPASS=0 (default)
  //   1: ZERO_REG=0 BYPASS=0
  //   2: ZERO_REG=1 BYPASS=1
  logic [31:0] rd1_o [3];
  logic [31:0] rd2_o [3];
  logic        conf_o [3];

  register_file_2w #(.WIDTH(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut (
    .clk(clk), .reset(reset), .A1(a1), .A2(a2), .A3(a3), .WD3(wd3), .WE(we),
    .A4(a4), .WD4(wd4), .WE4(we4), .RD1(rd1_o[0]), .RD2(rd2_o[0]), .WR_CONFLICT(conf_o[0]));

  register_file_2w #(.WIDTH(32), .ADDR_W(5), .ZERO_REG(1'b0), .BYPASS(1'b0)) dut_nz (
    .clk(clk), .reset(reset), .A1(a1), .A2(a2), .A3(a3), .WD3(wd3), .WE(we),
    .A4(a4), .WD4(wd4), .WE4(we4), .RD1(rd1_o[1]), .RD2(rd2_o[1]), .WR_CONFLICT(conf_o[1]));

  register_file_2w #(.WIDTH(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_byp (
    .clk(clk), .reset(reset), .A1(a1), .A2(a2), .A3(a3), .WD3(wd3), .WE(we),
    .A4(a4), .WD4(wd4), .WE4(we4), .RD1(rd1_o[2]), .RD2(rd2_o[2]), .WR_CONFLICT(conf_o[2]));

  // ---------------- reference model ----------------
  logic [31:0] mem [3][32];
  logic        exp_conf [3];

  int n_cmp = 0;
  int n_err = 0;

  function automatic bit cfg_zero(int cfg);
    return (cfg != 1);
  endfunction

  function automatic bit cfg_byp(int cfg);
    return (cfg == 2);
  endfunction

  function automatic logic [31:0] exp_rd(int cfg, logic [4:0] a);
    if (reset) return 32'h0;
    if (cfg_zero(cfg) && a == 5'd0) return 32'h0;
    if (cfg_byp(cfg) && we4 === 1'b1 && a4 == a) return wd4;
    if (cfg_byp(cfg) && we === 1'b1 && a3 == a) return wd3;
    return mem[cfg][a];
  endfunction

  task automatic model_clear();
    for (int c = 0; c < 3; c++) begin
      for (int r = 0; r < 32; r++) mem[c][r] = 32'h0;
      exp_conf[c] = 1'b0;
    end
  endtask

  // Advance one rising edge, applying the write rules to the model, then
  // settle 1 time unit so outputs are sampled away from the edge.
  task automatic tick();
    bit w3, w4;
    @(posedge clk);
    for (int c = 0; c < 3; c++) begin
      if (reset) begin
        exp_conf[c] = 1'b0;
      end else begin
        w3 = (we === 1'b1) && !(cfg_zero(c) && a3 == 5'd0);
        w4 = (we4 === 1'b1) && !(cfg_zero(c) && a4 == 5'd0);
        if (w3) mem[c][a3] = wd3;
        if (w4) mem[c][a4] = wd4;
        exp_conf[c] = w3 && w4 && (a3 == a4);
      end
    end
    #1;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    for (int c = 0; c < 3; c++) begin
      check($sformatf("%s/cfg%0d/RD1", tag, c), rd1_o[c], exp_rd(c, a1));
      check($sformatf("%s/cfg%0d/RD2", tag, c), rd2_o[c], exp_rd(c, a2));
      check($sformatf("%s/cfg%0d/CONF", tag, c), {31'h0, conf_o[c]}, {31'h0, exp_conf[c]});
    end
  endtask

  task automatic idle_inputs();
    we = 1'b0; we4 = 1'b0;
    a1 = '0; a2 = '0; a3 = '0; a4 = '0;
    wd3 = '0; wd4 = '0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "timeout");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    reset = 1'b1;
    idle_inputs();
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset_held");
    #2 reset = 1'b0;
    #1;

    // Sweep all addresses after reset: everything reads zero, no conflict.
    for (int i = 0; i < 32; i++) begin
      a1 = i[4:0];
      a2 = 5'(31 - i);
      #1;
      check_all("sweep");
      tick();
    end

    // Single write on port 3 to the top register.
    we = 1'b1; a3 = 5'd31; wd3 = 32'd5890;
    tick();
    we = 1'b0; a2 = 5'd31; a1 = 5'd1;
    #1;
    check("w31/RD2", rd2_o[0], 32'd5890);
    check("w31/RD1", rd1_o[0], 32'd0);
    check_all("w31");

    // Both ports to register 7: port 4 wins, conflict flag for one cycle.
    we = 1'b1; a3 = 5'd7; wd3 = 32'hAAAA_0001;
    we4 = 1'b1; a4 = 5'd7; wd4 = 32'h5555_0002;
    tick();
    we = 1'b0; we4 = 1'b0; a1 = 5'd7; a2 = 5'd7;
    #1;
    check("conf7/RD1", rd1_o[0], 32'h5555_0002);
    check("conf7/FLAG", {31'h0, conf_o[0]}, 32'd1);
    check_all("conf7");
    tick();
    check("conf7/FLAG_clear", {31'h0, conf_o[0]}, 32'd0);
    check_all("conf7_after");

    // Write to address 0: ignored when hardwired, kept otherwise.
    we = 1'b1; a3 = 5'd0; wd3 = 32'hFFFF_FFFF;
    tick();
    we = 1'b0; a1 = 5'd0;
    #1;
    check("zero/cfg0", rd1_o[0], 32'h0);
    check("zero/cfg1", rd1_o[1], 32'hFFFF_FFFF);
    check_all("zero");

    // Collision at address 0: flag only where register 0 is writable.
    we = 1'b1; we4 = 1'b1; a3 = 5'd0; a4 = 5'd0; wd3 = 32'h1111; wd4 = 32'h2222;
    tick();
    we = 1'b0; we4 = 1'b0;
    #1;
    check("conf0/cfg0", {31'h0, conf_o[0]}, 32'd0);
    check("conf0/cfg1", {31'h0, conf_o[1]}, 32'd1);
    check_all("conf0");

    // Bypass: reg5 = 3, then a pending port-4 write of 9.
    we = 1'b1; a3 = 5'd5; wd3 = 32'd3;
    tick();
    we = 1'b0; we4 = 1'b1; a4 = 5'd5; wd4 = 32'd9; a1 = 5'd5;
    #1;
    check("byp/pre_bypass", rd1_o[2], 32'd9);
    check("byp/pre_plain", rd1_o[0], 32'd3);
    check_all("byp_pre");
    tick();
    we4 = 1'b0;
    #1;
    check("byp/post_plain", rd1_o[0], 32'd9);
    check_all("byp_post");

    // Bypass priority (port 4 over port 3) and address 0 forced to zero.
    we = 1'b1; we4 = 1'b1; a3 = 5'd6; a4 = 5'd6; wd3 = 32'hA3A3; wd4 = 32'hB4B4;
    a1 = 5'd6; a2 = 5'd0;
    #1;
    check("byp/prio", rd1_o[2], 32'hB4B4);
    check_all("byp_prio");
    a4 = 5'd0; a3 = 5'd0; a1 = 5'd0;
    #1;
    check("byp/zero", rd1_o[2], 32'h0);
    check_all("byp_zero");
    tick();
    we = 1'b0; we4 = 1'b0;

    // Unknown enable must not write anything.
    we = 1'bx; a3 = 5'd9; wd3 = 32'hDEAD_BEEF; a1 = 5'd9;
    tick();
    we = 1'b0;
    #1;
    check_all("x_enable");

    // Reset mid-cycle with a write pending.
    we = 1'b1; a3 = 5'd12; wd3 = 32'd42;
    tick();
    we = 1'b1; a3 = 5'd12; wd3 = 32'd1; a1 = 5'd12; a2 = 5'd12;
    we4 = 1'b1; a4 = 5'd12; wd4 = 32'd77;
    #1;
    check("rst/before", rd1_o[0], 32'd42);
    #1 reset = 1'b1;
    model_clear();
    #1;
    check("rst/immediate", rd1_o[0], 32'd0);
    check("rst/bypass_forced", rd1_o[2], 32'd0);
    check_all("rst_immediate");
    tick();
    check_all("rst_held_edge");
    #2 reset = 1'b0;
    we = 1'b0; we4 = 1'b0;
    #1;
    check_all("rst_released");
    tick();
    check("rst/after", rd1_o[0], 32'd0);
    check_all("rst_after");

    // Randomized traffic; narrow address range half the time to force hits.
    for (int n = 0; n < 400; n++) begin
      bit narrow;
      narrow = ($urandom_range(0, 1) == 1);
      we  = 1'($urandom_range(0, 1));
      we4 = 1'($urandom_range(0, 1));
      a3  = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      a4  = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      a1  = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      a2  = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      wd3 = $urandom;
      wd4 = $urandom;
      #1;
      check_all("rand_pre");
      tick();
      check_all("rand_post");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
